// File: rtl/packet_scheduler.sv
// ---------------------------------------------------------------------------
// packet_scheduler
//
// Picks which programmable infoframe-style packet goes out in each packet
// opportunity. Each slot repeats once every (period+1) video fields; slots
// that have come due are kept pending and served round-robin on each
// packet_enable. When nothing is pending, a null packet (all zero) is sent.
//
// Optional feature macro: PACKET_SCHEDULER_MISSED_COUNT_EN
//   defined   -> per-slot saturating counters of sends lost because the slot
//                came due again while still pending.
//   undefined -> missed_count is tied to 0.
//
// Ports
//   clk_pixel        pixel clock, all logic on rising edge
//   reset_n          asynchronous active-low reset
//   video_field_end  one-cycle pulse at the end of each field
//   packet_enable    one-cycle pulse requesting the next selection
//   cfg_wr/addr/wdata  slot data write; addr = {slot[2:0], word[2:0]},
//                      word 0 = header[23:0], word w = sub[32(w-1)+:32]
//   ctrl_wr/slot/enable/period  slot control write
//   header, sub      selected packet contents (shadow registers)
//   packet_slot      selected slot index, 0 for null
//   packet_is_null   high when the null packet is selected
//   missed_count     per-slot missed-send counters, slot i at [8i+:8]
// ---------------------------------------------------------------------------
module packet_scheduler #(
    parameter int NUM_SLOTS = 4,
    parameter int PERIOD_W  = 4
) (
    input  logic                   clk_pixel,
    input  logic                   reset_n,
    input  logic                   video_field_end,
    input  logic                   packet_enable,
    input  logic                   cfg_wr,
    input  logic [5:0]             cfg_addr,
    input  logic [31:0]            cfg_wdata,
    input  logic                   ctrl_wr,
    input  logic [2:0]             ctrl_slot,
    input  logic                   ctrl_enable,
    input  logic [PERIOD_W-1:0]    ctrl_period,
    output logic [23:0]            header,
    output logic [223:0]           sub,
    output logic [2:0]             packet_slot,
    output logic                   packet_is_null,
    output logic [8*NUM_SLOTS-1:0] missed_count
);

    // Storage is sized for the 3-bit slot address space so every slot index
    // is in range; slots at or above NUM_SLOTS are never written and stay 0.
    localparam int         MAX_SLOTS = 8;
    localparam logic [3:0] NSLOTS    = 4'(NUM_SLOTS);

    logic [23:0]          hdr_mem [MAX_SLOTS];
    logic [223:0]         sub_mem [MAX_SLOTS];
    logic [PERIOD_W-1:0]  period  [MAX_SLOTS];
    logic [PERIOD_W-1:0]  cnt     [MAX_SLOTS];
    logic [MAX_SLOTS-1:0] slot_en;
    logic [MAX_SLOTS-1:0] pending;
    logic [2:0]           rr;

    logic [2:0] cfg_slot;
    logic [2:0] cfg_word;
    logic       cfg_hit;
    logic       ctrl_hit;

    logic [3:0] idx;
    logic       found;
    logic [2:0] sel;

    assign cfg_slot = cfg_addr[5:3];
    assign cfg_word = cfg_addr[2:0];
    assign cfg_hit  = cfg_wr  && ({1'b0, cfg_slot}  < NSLOTS);
    assign ctrl_hit = ctrl_wr && ({1'b0, ctrl_slot} < NSLOTS);

    // First pending slot at or after rr, wrapping modulo NUM_SLOTS.
    always_comb begin
        found = 1'b0;
        sel   = 3'd0;
        idx   = 4'd0;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            idx = {1'b0, rr} + 4'(k);
            if (idx >= NSLOTS) idx = idx - NSLOTS;
            if (!found && pending[idx[2:0]]) begin
                found = 1'b1;
                sel   = idx[2:0];
            end
        end
    end

`ifdef PACKET_SCHEDULER_MISSED_COUNT_EN
    logic [7:0] missed [MAX_SLOTS];

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_missed
        assign missed_count[8*g +: 8] = missed[g];
    end
`else
    assign missed_count = '0;
`endif

    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < MAX_SLOTS; i++) begin
                hdr_mem[i] <= '0;
                sub_mem[i] <= '0;
                period[i]  <= '0;
                cnt[i]     <= '0;
`ifdef PACKET_SCHEDULER_MISSED_COUNT_EN
                missed[i]  <= '0;
`endif
            end
            slot_en        <= '0;
            pending        <= '0;
            rr             <= 3'd0;
            header         <= '0;
            sub            <= '0;
            packet_slot    <= 3'd0;
            packet_is_null <= 1'b1;
        end else begin
            // A selection coinciding with a field end is forced to null so
            // the field-end pending update is never racing a pending clear.
            if (packet_enable) begin
                if (found && !video_field_end) begin
                    header         <= hdr_mem[sel];
                    sub            <= sub_mem[sel];
                    packet_slot    <= sel;
                    packet_is_null <= 1'b0;
                    pending[sel]   <= 1'b0;
                    rr <= ({1'b0, sel} + 4'd1 == NSLOTS) ? 3'd0 : sel + 3'd1;
                end else begin
                    header         <= '0;
                    sub            <= '0;
                    packet_slot    <= 3'd0;
                    packet_is_null <= 1'b1;
                end
            end

            if (video_field_end) begin
                for (int i = 0; i < MAX_SLOTS; i++) begin
                    if (slot_en[i]) begin
                        if (cnt[i] == '0) begin
                            pending[i] <= 1'b1;
                            cnt[i]     <= period[i];
`ifdef PACKET_SCHEDULER_MISSED_COUNT_EN
                            if (pending[i] && missed[i] != 8'hFF)
                                missed[i] <= missed[i] + 8'd1;
`endif
                        end else begin
                            cnt[i] <= cnt[i] - 1'b1;
                        end
                    end else begin
                        pending[i] <= 1'b0;
                        cnt[i]     <= '0;
                    end
                end
            end

            // Shadow outputs were loaded from the old contents above, so a
            // write landing with a selection of the same slot shows next time.
            if (cfg_hit) begin
                if (cfg_word == 3'd0) begin
                    hdr_mem[cfg_slot] <= cfg_wdata[23:0];
                end else begin
                    for (int w = 1; w < 8; w++) begin
                        if (cfg_word == 3'(w))
                            sub_mem[cfg_slot][32*(w-1) +: 32] <= cfg_wdata;
                    end
                end
            end

            // Clearing cnt makes the slot due at the very next field end.
            if (ctrl_hit) begin
                slot_en[ctrl_slot] <= ctrl_enable;
                period[ctrl_slot]  <= ctrl_period;
                cnt[ctrl_slot]     <= '0;
            end
        end
    end

endmodule
